// File: rtl/frontpanel_key_event_encoder_if.sv
// Key event stream between the encoder and the front-panel AXI/interrupt logic.
// Latency: none, wires only.
// Backpressure: the consumer holds EVT_READY low to stall the head event.
interface frontpanel_key_event_encoder_if;
    logic       EVT_VALID;
    logic       EVT_READY;
    logic [7:0] EVT_DATA;

    // Event producer: presents the FIFO head
    modport master (
        output EVT_VALID,
        output EVT_DATA,
        input  EVT_READY
    );

    // Event consumer: accepts the head when ready
    modport slave (
        input  EVT_VALID,
        input  EVT_DATA,
        output EVT_READY
    );
endinterface

// File: rtl/frontpanel_key_event_encoder.sv
// Debounces every front-panel button across scanner snapshots and queues press/release events.
// Latency: button i of a snapshot strobed in cycle t is evaluated at t+1+i; its event heads an empty FIFO at t+2+i.
// Backpressure: EVT_READY low fills the FIFO; further events are dropped (OVERFLOW) while debounce state still advances.
module frontpanel_key_event_encoder #(
    parameter int BUTTON_COUNT   = 64,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          SNAP_VALID,
    input  logic [BUTTON_COUNT-1:0]       SNAP_DATA,
    frontpanel_key_event_encoder_if.master evt,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    output logic                          SNAP_DROPPED,
    input  logic                          FLAG_CLR,
    output logic                          BUSY
);
    localparam int IDX_W = $clog2(BUTTON_COUNT);
    localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int LW    = PW + 1;
    localparam logic [LW-1:0]    DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(BUTTON_COUNT - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state;
    logic                    busy;
    logic [IDX_W-1:0]        idx;
    logic [BUTTON_COUNT-1:0] shadow;
    logic [BUTTON_COUNT-1:0] stable;
    logic [CW-1:0]           cnt [BUTTON_COUNT];

    logic [7:0]              mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    logic                    raw_bit;
    logic [CW-1:0]           cur_cnt;
    logic                    differs;
    logic                    accept_chg;
    logic [6:0]              evt_idx;
    logic [7:0]              evt_word;
    logic                    evt_vld;
    logic                    pop;
    logic                    push_ok;
    logic                    snap_drop;
    logic                    last_idx;

    // Evaluate the button under the scan index and decide whether its change is accepted
    always_comb begin
        raw_bit    = shadow[idx];
        cur_cnt    = cnt[idx];
        differs    = (state == SCAN) && (raw_bit != stable[idx]);
        accept_chg = differs && ((int'(cur_cnt) + 1) == DEBOUNCE_SCANS);
        evt_idx    = '0;
        evt_idx[IDX_W-1:0] = idx;
        evt_word   = {raw_bit, evt_idx};
        evt_vld    = (FIFO_LEVEL != '0);
        pop        = evt_vld && evt.EVT_READY;
        // A full FIFO still takes the event when the head leaves in the same cycle
        push_ok    = accept_chg && ((FIFO_LEVEL < DEPTH_L) || pop);
        snap_drop  = SNAP_VALID && (state == SCAN);
        last_idx   = (idx == LAST_I);
    end

    assign evt.EVT_VALID = evt_vld;
    assign evt.EVT_DATA  = evt_vld ? mem[rd_ptr] : 8'h00;
    assign BUSY          = busy;

    // Scan sequencer: latch a snapshot in IDLE, then walk one button per cycle
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state  <= IDLE;
            busy   <= 1'b0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (SNAP_VALID) begin
                        shadow <= SNAP_DATA;
                        idx    <= '0;
                        state  <= SCAN;
                        busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_idx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-button debounce: count consecutive disagreeing scans, commit the level after enough of them
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            stable <= '0;
            for (int i = 0; i < BUTTON_COUNT; i++) begin
                cnt[i] <= '0;
            end
        end else if (state == SCAN) begin
            if (!differs) begin
                cnt[idx] <= '0;
            end else if (accept_chg) begin
                // Committed even when the FIFO drops the event, so it is never re-emitted
                stable[idx] <= raw_bit;
                cnt[idx]    <= '0;
            end else begin
                cnt[idx] <= cur_cnt + CW'(1);
            end
        end
    end

    // Event storage; contents need no reset because the level gates visibility
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= evt_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop) begin
                FIFO_LEVEL <= FIFO_LEVEL + LW'(1);
            end else if (pop && !push_ok) begin
                FIFO_LEVEL <= FIFO_LEVEL - LW'(1);
            end
        end
    end

    // Sticky status flags; a new set condition overrides a simultaneous clear
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            OVERFLOW     <= 1'b0;
            SNAP_DROPPED <= 1'b0;
        end else begin
            if (accept_chg && !push_ok) OVERFLOW <= 1'b1;
            else if (FLAG_CLR)          OVERFLOW <= 1'b0;
            if (snap_drop)              SNAP_DROPPED <= 1'b1;
            else if (FLAG_CLR)          SNAP_DROPPED <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frontpanel_key_event_encoder.sv
// Self-checking bench for the key event encoder: directed scenarios plus randomized snapshots.
// Latency: checks button-5 event timing against the strobe cycle.
// Backpressure: exercises stalled, overflowing and randomly-ready consumers.
module tb_frontpanel_key_event_encoder;
    localparam int BC = 64;
    localparam int DS = 3;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snap_valid = 1'b0;
    logic [BC-1:0] snap_data = '0;
    logic          flag_clr = 1'b0;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          snap_dropped;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: committed levels, disagreement counts, expected events
    logic [BC-1:0] mdl_stable;
    int            mdl_cnt [BC];
    logic [7:0]    exp_q [$];
    logic [7:0]    got_q [$];

    frontpanel_key_event_encoder_if evt_if ();

    frontpanel_key_event_encoder #(
        .BUTTON_COUNT   (BC),
        .DEBOUNCE_SCANS (DS),
        .FIFO_DEPTH     (FD)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .SNAP_VALID    (snap_valid),
        .SNAP_DATA     (snap_data),
        .evt           (evt_if),
        .FIFO_LEVEL    (fifo_level),
        .OVERFLOW      (overflow),
        .SNAP_DROPPED  (snap_dropped),
        .FLAG_CLR      (flag_clr),
        .BUSY          (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted event, sampled mid-cycle before the popping edge
    always @(negedge clk) begin
        if (rst_n && evt_if.EVT_VALID && evt_if.EVT_READY) got_q.push_back(evt_if.EVT_DATA);
    end

    task automatic model_clear();
        mdl_stable = '0;
        for (int i = 0; i < BC; i++) mdl_cnt[i] = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Apply one whole snapshot to the model; at most 'room' events fit in the FIFO
    task automatic model_snap(input logic [BC-1:0] d, input int room);
        int left;
        left = room;
        for (int i = 0; i < BC; i++) begin
            if (d[i] == mdl_stable[i]) begin
                mdl_cnt[i] = 0;
            end else if (mdl_cnt[i] + 1 == DS) begin
                mdl_stable[i] = d[i];
                mdl_cnt[i] = 0;
                if (left > 0) begin
                    exp_q.push_back({d[i], 7'(i)});
                    left--;
                end
            end else begin
                mdl_cnt[i]++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        snap_valid = 1'b0;
        flag_clr = 1'b0;
        snap_data = '0;
        evt_if.EVT_READY = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    // One-cycle strobe; returns 1 ns after the sampling edge
    task automatic start_snap(input logic [BC-1:0] d);
        @(posedge clk); #1;
        snap_valid = 1'b1;
        snap_data = d;
        @(posedge clk); #1;
        snap_valid = 1'b0;
    endtask

    // Full snapshot; first_vld = cycle offset (t+k) where EVT_VALID is first seen, -1 if never
    task automatic send_snap(input logic [BC-1:0] d, input int room, output int first_vld);
        start_snap(d);
        model_snap(d, room);
        first_vld = -1;
        for (int k = 1; k <= BC + 2; k++) begin
            @(negedge clk);
            if (evt_if.EVT_VALID && first_vld < 0) first_vld = k;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        checks++; if (evt_if.EVT_VALID !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b want 0", evt_if.EVT_VALID); end
        checks++; if (evt_if.EVT_DATA !== 8'h00) begin errors++; $display("FAIL reset_evt_data got %h want 00", evt_if.EVT_DATA); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (snap_dropped !== 1'b0) begin errors++; $display("FAIL reset_snap_dropped got %b want 0", snap_dropped); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_debounce_accept();
        int fv;
        got_q.delete();
        send_snap(64'h20, 1000, fv);
        send_snap(64'h20, 1000, fv);
        checks++; if (got_q.size() != 0 || fv != -1) begin errors++; $display("FAIL accept_early got %0d events want 0", got_q.size()); end
        send_snap(64'h20, 1000, fv);
        checks++; if (fv != 7) begin errors++; $display("FAIL accept_timing got t+%0d want t+7", fv); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL accept_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h85) begin errors++; $display("FAIL accept_data got %h want 85", got_q[0]); end
        end
    endtask

    task automatic test_release();
        int fv;
        got_q.delete();
        for (int n = 0; n < 3; n++) send_snap('0, 1000, fv);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL release_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h05) begin errors++; $display("FAIL release_data got %h want 05", got_q[0]); end
        end
    endtask

    task automatic test_glitch();
        int fv;
        logic [BC-1:0] seq [5];
        seq = '{64'h20, 64'h20, 64'h00, 64'h20, 64'h20};
        got_q.delete();
        for (int n = 0; n < 5; n++) send_snap(seq[n], 1000, fv);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_none got %0d events want 0", got_q.size()); end
        send_snap(64'h20, 1000, fv);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL glitch_after got %0d events want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h85) begin errors++; $display("FAIL glitch_data got %h want 85", got_q[0]); end
        end
    endtask

    task automatic test_overflow();
        int fv;
        bit order_ok;
        do_reset();
        evt_if.EVT_READY = 1'b0;
        for (int n = 0; n < 3; n++) send_snap('1, FD, fv);
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        repeat (3) @(negedge clk);
        checks++; if (evt_if.EVT_DATA !== 8'h80) begin errors++; $display("FAIL ovf_head_stall got %h want 80", evt_if.EVT_DATA); end
        @(posedge clk); #1 evt_if.EVT_READY = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL ovf_drain_count got %0d want 16", got_q.size()); end
        order_ok = (got_q.size() == 16);
        for (int i = 0; i < got_q.size() && i < 16; i++) if (got_q[i] !== 8'(8'h80 + i)) order_ok = 1'b0;
        checks++; if (!order_ok) begin errors++; $display("FAIL ovf_drain_order got %p want 80..8f", got_q); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_empty got %0d want 0", fifo_level); end
        got_q.delete();
        send_snap('1, 1000, fv);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovf_no_reemit got %0d events want 0", got_q.size()); end
    endtask

    task automatic test_collision_clear();
        int fv;
        bit order_ok;
        got_q.delete();
        start_snap('1);
        model_snap('1, 1000);
        repeat (9) @(posedge clk); #1;
        snap_valid = 1'b1;
        snap_data = '0;
        @(posedge clk); #1 snap_valid = 1'b0;
        checks++; if (snap_dropped !== 1'b1) begin errors++; $display("FAIL coll_dropped got %b want 1", snap_dropped); end
        repeat (BC) @(posedge clk); #1;
        send_snap('0, 1000, fv);
        send_snap('0, 1000, fv);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL coll_state_kept got %0d events want 0", got_q.size()); end
        @(posedge clk); #1 flag_clr = 1'b1;
        @(posedge clk); #1 flag_clr = 1'b0;
        checks++; if (snap_dropped !== 1'b0) begin errors++; $display("FAIL clr_dropped got %b want 0", snap_dropped); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
        start_snap('0);
        model_snap('0, 1000);
        repeat (9) @(posedge clk); #1;
        snap_valid = 1'b1;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        snap_valid = 1'b0;
        flag_clr = 1'b0;
        checks++; if (snap_dropped !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", snap_dropped); end
        repeat (BC) @(posedge clk); #1;
        checks++; if (got_q.size() != BC) begin errors++; $display("FAIL coll_release_count got %0d want %0d", got_q.size(), BC); end
        order_ok = (got_q.size() == BC);
        for (int i = 0; i < got_q.size() && i < BC; i++) if (got_q[i] !== {1'b0, 7'(i)}) order_ok = 1'b0;
        checks++; if (!order_ok) begin errors++; $display("FAIL coll_release_order got %p", got_q); end
    endtask

    task automatic test_scan_boundary();
        @(posedge clk); #1 flag_clr = 1'b1;
        @(posedge clk); #1 flag_clr = 1'b0;
        got_q.delete();
        start_snap('0);
        model_snap('0, 1000);
        repeat (63) @(posedge clk); #1;
        snap_valid = 1'b1;
        snap_data = '0;
        @(posedge clk); #1;
        checks++; if (snap_dropped !== 1'b1) begin errors++; $display("FAIL edge_last_cycle_drop got %b want 1", snap_dropped); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_idle got %b want 0", busy); end
        @(posedge clk); #1;
        snap_valid = 1'b0;
        model_snap('0, 1000);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL edge_next_accept got %b want 1", busy); end
        repeat (BC + 2) @(posedge clk); #1;
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL edge_no_events got %0d want 0", got_q.size()); end
    endtask

    task automatic test_async_reset();
        int fv;
        got_q.delete();
        evt_if.EVT_READY = 1'b0;
        send_snap(64'h7, FD, fv);
        send_snap(64'h7, FD, fv);
        start_snap(64'h7);
        repeat (14) @(posedge clk); #1 snap_valid = 1'b1;
        @(posedge clk); #1 snap_valid = 1'b0;
        repeat (5) @(posedge clk); #2;
        checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL arst_pre_level got %0d want 3", fifo_level); end
        checks++; if (busy !== 1'b1 || snap_dropped !== 1'b1) begin errors++; $display("FAIL arst_pre_state got busy=%b drop=%b want 1 1", busy, snap_dropped); end
        rst_n = 1'b0;
        #1;
        checks++; if (evt_if.EVT_VALID !== 1'b0) begin errors++; $display("FAIL arst_evt_valid got %b want 0", evt_if.EVT_VALID); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL arst_level got %0d want 0", fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (snap_dropped !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_flags got drop=%b ovf=%b want 0 0", snap_dropped, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        evt_if.EVT_READY = 1'b1;
        for (int n = 0; n < 3; n++) send_snap('0, 1000, fv);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL arst_no_partial got %0d events want 0", got_q.size()); end
    endtask

    task automatic test_random();
        bit done;
        int fv;
        logic [BC-1:0] mask;
        logic [BC-1:0] d;
        int nb;
        int rep;
        done = 1'b0;
        got_q.delete();
        exp_q.delete();
        fork
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    evt_if.EVT_READY = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    mask = '0;
                    nb = $urandom_range(1, 4);
                    rep = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) mask[$urandom_range(0, BC - 1)] = 1'b1;
                    d = mdl_stable ^ mask;
                    for (int r = 0; r < rep; r++) send_snap(d, 1000, fv);
                    for (int w = 0; w < 64 && fifo_level != 5'd0; w++) @(posedge clk);
                end
                done = 1'b1;
            end
        join
        @(posedge clk); #1 evt_if.EVT_READY = 1'b1;
        repeat (20) @(posedge clk); #1;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %b want 0", overflow); end
    endtask

    initial begin
        evt_if.EVT_READY = 1'b1;
        test_reset();
        test_debounce_accept();
        test_release();
        test_glitch();
        test_overflow();
        test_collision_clear();
        test_scan_boundary();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
